// File: rtl/fpu_pkg.sv
// Shared format helpers, FSM state type and special-value encodings for the
// FPU blocks (fpu_divide, fpu_multiply).
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      NORM,
      DONE
   } fpuState_e;

   localparam logic [63:0] QNAN_SINGLE = 64'h0000_0000_7FC0_0000;
   localparam logic [63:0] QNAN_DOUBLE = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] INF_SINGLE  = 64'h0000_0000_7F80_0000;
   localparam logic [63:0] INF_DOUBLE  = 64'h7FF0_0000_0000_0000;

   function automatic int fpuWidth(input int dbl);
      return (dbl != 0) ? 64 : 32;
   endfunction

   function automatic int fpuExpWidth(input int dbl);
      return (dbl != 0) ? 11 : 8;
   endfunction

   function automatic int fpuManWidth(input int dbl);
      return (dbl != 0) ? 52 : 23;
   endfunction

   function automatic int fpuBias(input int dbl);
      return (dbl != 0) ? 1023 : 127;
   endfunction

   // Encodings are returned zero-extended to 64 bits; callers take the low bits.
   function automatic logic [63:0] fpuQnan(input int dbl);
      return (dbl != 0) ? QNAN_DOUBLE : QNAN_SINGLE;
   endfunction

   function automatic logic [63:0] fpuInf(input int dbl);
      return (dbl != 0) ? INF_DOUBLE : INF_SINGLE;
   endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier: splits an IEEE-754 word into its fields,
// flags zero/denormal and inf/NaN, and restores the hidden leading one.
module fpu_classify
   import fpu_pkg::*;
#(
   parameter int  double = 0,
   localparam int W      = fpuWidth(double),
   localparam int E      = fpuExpWidth(double),
   localparam int M      = fpuManWidth(double)
) (
   input  logic [W-1:0] op_i,
   output logic         sign_o,
   output logic [E-1:0] exp_o,
   output logic [M:0]   frac_o,
   output logic         isZero_o,
   output logic         isSpecial_o
);

   assign sign_o      = op_i[W-1];
   assign exp_o       = op_i[W-2 -: E];
   assign isZero_o    = (exp_o == '0);
   assign isSpecial_o = &exp_o;

   // Denormals are flushed, so a zero exponent field yields an all-zero fraction.
   assign frac_o      = isZero_o ? '0 : {1'b1, op_i[M-1:0]};

endmodule

// File: rtl/fpu_divide.sv
// Iterative IEEE-754 divider: special cases resolve at acceptance, normal
// operands run a restoring radix-2 divide, then normalize and truncate.
module fpu_divide
   import fpu_pkg::*;
#(
   parameter int  double = 0,
   localparam int W      = fpuWidth(double),
   localparam int E      = fpuExpWidth(double),
   localparam int M      = fpuManWidth(double),
   localparam int BIAS   = fpuBias(double)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result
);

   localparam int QW = M + 2;
   localparam int XW = E + 2;
   localparam int CW = $clog2(QW);

   localparam logic [63:0]          QNAN64   = fpuQnan(double);
   localparam logic [63:0]          INF64    = fpuInf(double);
   localparam logic [W-1:0]         QNAN     = QNAN64[W-1:0];
   localparam logic [W-1:0]         INF      = INF64[W-1:0];
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << E) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
   localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);

   fpuState_e             state_q;
   logic                  sign_q;
   logic signed [XW-1:0]  exp_q;
   logic [QW-1:0]         rem_q;
   logic [M:0]            divisor_q;
   logic [QW-1:0]         quo_q;
   logic [CW-1:0]         cnt_q;
   logic                  normStep_q;
   logic [W-1:0]          result_q;
   logic                  outValid_q;

   logic                  signA, signB;
   logic [E-1:0]          expA, expB;
   logic [M:0]            fracA, fracB;
   logic                  zeroA, zeroB;
   logic                  specialA, specialB;

   logic                  remGe;
   logic [QW-1:0]         remSub_d;
   logic [QW-1:0]         remShift_d;
   logic signed [XW-1:0]  expStart_d;
   logic                  signRes;

   fpu_classify #(.double(double)) classifyA (
      .op_i        (a),
      .sign_o      (signA),
      .exp_o       (expA),
      .frac_o      (fracA),
      .isZero_o    (zeroA),
      .isSpecial_o (specialA)
   );

   fpu_classify #(.double(double)) classifyB (
      .op_i        (b),
      .sign_o      (signB),
      .exp_o       (expB),
      .frac_o      (fracB),
      .isZero_o    (zeroB),
      .isSpecial_o (specialB)
   );

   // One restoring step: subtract when possible, then shift the partial remainder.
   assign remGe      = (rem_q >= {1'b0, divisor_q});
   assign remSub_d   = remGe ? (rem_q - {1'b0, divisor_q}) : rem_q;
   assign remShift_d = {remSub_d[QW-2:0], 1'b0};

   assign expStart_d = $signed({2'b00, expA}) - $signed({2'b00, expB}) + BIAS_X;
   assign signRes    = signA ^ signB;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = outValid_q;
   assign result     = result_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         rem_q      <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         normStep_q <= 1'b0;
         result_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= signRes;
                  if (specialA || specialB || (zeroA && zeroB)) begin
                     result_q   <= QNAN;
                     outValid_q <= 1'b1;
                     state_q    <= DONE;
                  end else if (zeroB) begin
                     result_q   <= {signRes, INF[W-2:0]};
                     outValid_q <= 1'b1;
                     state_q    <= DONE;
                  end else if (zeroA) begin
                     result_q   <= {signRes, {(W-1){1'b0}}};
                     outValid_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     exp_q     <= expStart_d;
                     rem_q     <= {1'b0, fracA};
                     divisor_q <= fracB;
                     quo_q     <= '0;
                     cnt_q     <= '0;
                     state_q   <= DIVIDE;
                  end
               end
            end

            DIVIDE: begin
               quo_q <= {quo_q[QW-2:0], remGe};
               rem_q <= remShift_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  normStep_q <= 1'b0;
                  state_q    <= NORM;
               end
            end

            // First NORM cycle aligns the quotient, second range-checks and packs.
            NORM: begin
               if (!normStep_q) begin
                  normStep_q <= 1'b1;
                  if (!quo_q[QW-1]) begin
                     quo_q <= {quo_q[QW-2:0], 1'b0};
                     exp_q <= exp_q - EXP_ONE;
                  end
               end else begin
                  if (exp_q >= EXP_MAX) begin
                     result_q <= {sign_q, INF[W-2:0]};
                  end else if (exp_q <= EXP_ZERO) begin
                     result_q <= {sign_q, {(W-1){1'b0}}};
                  end else begin
                     result_q <= {sign_q, exp_q[E-1:0], quo_q[QW-2 -: M]};
                  end
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_divide.sv
// Self-checking bench for fpu_divide: directed corner cases plus randomized
// operands compared against an integer-arithmetic reference model.
module tb_fpu_divide;

   logic        clk = 1'b0;
   logic        rst;

   logic        inValidS, inReadyS, outValidS, outReadyS;
   logic [31:0] aS, bS, resultS;
   logic        inValidD, inReadyD, outValidD, outReadyD;
   logic [63:0] aD, bD, resultD;

   int vectorCount = 0;
   int missCount   = 0;

   always #5 clk = ~clk;

   fpu_divide #(.double(0)) dutS (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValidS),
      .in_ready  (inReadyS),
      .a         (aS),
      .b         (bS),
      .out_valid (outValidS),
      .out_ready (outReadyS),
      .result    (resultS)
   );

   fpu_divide #(.double(1)) dutD (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValidD),
      .in_ready  (inReadyD),
      .a         (aD),
      .b         (bD),
      .out_valid (outValidD),
      .out_ready (outReadyD),
      .result    (resultD)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Quotient from a plain integer divide of the hidden-bit mantissas.
   function automatic logic [63:0] refDivide(input bit dbl, input logic [63:0] av,
                                             input logic [63:0] bv);
      int          m        = dbl ? 52 : 23;
      int          e        = dbl ? 11 : 8;
      int          bias     = dbl ? 1023 : 127;
      int          w        = dbl ? 64 : 32;
      logic [63:0] eMask    = (64'd1 << e) - 64'd1;
      logic [63:0] fracMask = (64'd1 << m) - 64'd1;
      logic [63:0] qnan     = dbl ? 64'h7FF8000000000000 : 64'h000000007FC00000;
      logic [63:0] inf      = dbl ? 64'h7FF0000000000000 : 64'h000000007F800000;
      longint      eMax     = longint'(eMask);
      longint      ea       = longint'((av >> m) & eMask);
      longint      eb       = longint'((bv >> m) & eMask);
      logic        s        = av[w-1] ^ bv[w-1];
      logic [63:0] sMask    = s ? (64'd1 << (w - 1)) : 64'd0;
      logic [127:0] num, den, quo;
      logic [63:0] frac;
      longint      ex;
      if (ea == eMax || eb == eMax) return qnan;
      if (ea == 0 && eb == 0) return qnan;
      if (eb == 0) return sMask | inf;
      if (ea == 0) return sMask;
      num = 128'((av & fracMask) | (64'd1 << m)) << (m + 1);
      den = 128'((bv & fracMask) | (64'd1 << m));
      quo = num / den;
      ex  = ea - eb + longint'(bias);
      if ((quo >> (m + 1)) != 0) begin
         frac = 64'(quo >> 1) & fracMask;
      end else begin
         frac = 64'(quo) & fracMask;
         ex   = ex - 1;
      end
      if (ex >= eMax) return sMask | inf;
      if (ex <= 0) return sMask;
      return sMask | (64'(ex) << m) | frac;
   endfunction

   function automatic int expectedLatency(input bit dbl, input logic [63:0] av,
                                          input logic [63:0] bv);
      int          m     = dbl ? 52 : 23;
      logic [63:0] eMask = dbl ? 64'h7FF : 64'hFF;
      logic [63:0] ea    = (av >> m) & eMask;
      logic [63:0] eb    = (bv >> m) & eMask;
      if (ea == 0 || eb == 0 || ea == eMask || eb == eMask) return 0;
      return m + 4;
   endfunction

   function automatic logic [63:0] randOperand(input bit dbl);
      int          m    = dbl ? 52 : 23;
      int          w    = dbl ? 64 : 32;
      int          eTop = dbl ? 2047 : 255;
      int          cat  = int'($urandom_range(0, 9));
      logic [63:0] frac = {32'($urandom), 32'($urandom)} & ((64'd1 << m) - 64'd1);
      int          ex;
      logic [63:0] s    = 64'($urandom_range(0, 1)) << (w - 1);
      if (cat == 0)      ex = 0;
      else if (cat == 1) ex = eTop;
      else               ex = int'($urandom_range(1, eTop - 1));
      return s | (64'(ex) << m) | frac;
   endfunction

   // Drives one operation and leaves the DUT in DONE with its result checked.
   task automatic applyStimulus(input bit dbl, input logic [63:0] av, input logic [63:0] bv,
                                input string tag);
      logic [63:0] expRes;
      logic [63:0] got;
      int          lat;
      int          expLat;
      expRes = refDivide(dbl, av, bv);
      expLat = expectedLatency(dbl, av, bv);
      @(negedge clk);
      checkOutput({tag, "_ready"}, 64'(dbl ? inReadyD : inReadyS), 64'd1);
      if (dbl) begin
         aD = av; bD = bv; inValidD = 1'b1;
      end else begin
         aS = av[31:0]; bS = bv[31:0]; inValidS = 1'b1;
      end
      @(negedge clk);
      inValidS = 1'b0;
      inValidD = 1'b0;
      lat = 0;
      while (!(dbl ? outValidD : outValidS) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      got = dbl ? resultD : {32'd0, resultS};
      checkOutput({tag, "_result"}, got, expRes);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
   endtask

   task automatic releaseResult(input bit dbl, input string tag);
      @(negedge clk);
      if (dbl) outReadyD = 1'b1; else outReadyS = 1'b1;
      @(negedge clk);
      outReadyS = 1'b0;
      outReadyD = 1'b0;
      checkOutput({tag, "_idleValid"}, 64'(dbl ? outValidD : outValidS), 64'd0);
      checkOutput({tag, "_idleReady"}, 64'(dbl ? inReadyD : inReadyS), 64'd1);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [31:0] heldResult;
      rst = 1'b1;
      inValidS = 1'b0; outReadyS = 1'b0; aS = '0; bS = '0;
      inValidD = 1'b0; outReadyD = 1'b0; aD = '0; bD = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_readyS", 64'(inReadyS), 64'd1);
      checkOutput("rst_validS", 64'(outValidS), 64'd0);
      checkOutput("rst_resultS", 64'(resultS), 64'd0);
      checkOutput("rst_readyD", 64'(inReadyD), 64'd1);
      checkOutput("rst_resultD", resultD, 64'd0);
      rst = 1'b0;

      applyStimulus(0, 64'h40C00000, 64'h40000000, "six_by_two");
      checkOutput("six_by_two_const", 64'(resultS), 64'h40400000);
      releaseResult(0, "six_by_two");

      applyStimulus(0, 64'h3F800000, 64'h40400000, "one_by_three");
      checkOutput("one_by_three_const", 64'(resultS), 64'h3EAAAAAA);
      releaseResult(0, "one_by_three");

      applyStimulus(0, 64'hBF800000, 64'h00000000, "neg_by_zero");
      checkOutput("neg_by_zero_const", 64'(resultS), 64'hFF800000);
      releaseResult(0, "neg_by_zero");

      applyStimulus(0, 64'h00000000, 64'h00000000, "zero_by_zero");
      checkOutput("zero_by_zero_const", 64'(resultS), 64'h7FC00000);
      releaseResult(0, "zero_by_zero");

      applyStimulus(0, 64'h7F000000, 64'h00800000, "overflow");
      checkOutput("overflow_const", 64'(resultS), 64'h7F800000);
      releaseResult(0, "overflow");

      applyStimulus(1, 64'h4018000000000000, 64'h4000000000000000, "dbl_six_by_two");
      checkOutput("dbl_six_by_two_const", resultD, 64'h4008000000000000);
      releaseResult(1, "dbl_six_by_two");

      // Stall in DONE with in_valid pulses that must be ignored.
      applyStimulus(0, 64'h40C00000, 64'h40000000, "stall");
      heldResult = resultS;
      for (int i = 0; i < 10; i++) begin
         aS = $urandom;
         bS = $urandom;
         inValidS = i[0];
         @(negedge clk);
         checkOutput("stall_result", 64'(resultS), 64'h40400000);
         checkOutput("stall_valid", 64'(outValidS), 64'd1);
         checkOutput("stall_ready", 64'(inReadyS), 64'd0);
      end
      inValidS = 1'b0;
      releaseResult(0, "stall");
      @(negedge clk);
      checkOutput("stall_noqueue", 64'(outValidS), 64'd0);
      checkOutput("stall_held", 64'(resultS), 64'(heldResult));

      // Reset asserted in the middle of a divide.
      @(negedge clk);
      aS = 32'h3F800000; bS = 32'h40400000; inValidS = 1'b1;
      @(negedge clk);
      inValidS = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("mid_busy", 64'(inReadyS), 64'd0);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 64'(outValidS), 64'd0);
      checkOutput("mid_rst_ready", 64'(inReadyS), 64'd1);
      checkOutput("mid_rst_result", 64'(resultS), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 64'h41200000, 64'h40A00000, "after_rst");
      checkOutput("after_rst_const", 64'(resultS), 64'h40000000);
      releaseResult(0, "after_rst");

      for (int i = 0; i < 60; i++) begin
         ra = randOperand(0);
         rb = randOperand(0);
         applyStimulus(0, ra, rb, "rand_s");
         releaseResult(0, "rand_s");
      end
      for (int i = 0; i < 8; i++) begin
         ra = randOperand(1);
         rb = randOperand(1);
         applyStimulus(1, ra, rb, "rand_d");
         releaseResult(1, "rand_d");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
